// File: rtl/axil_arbiter_pkg.sv
// Shared types and helpers for the AXI-Lite round-robin arbiter.
package axil_arbiter_pkg;

  // Transaction phases. The arbiter owns the downstream port from the first
  // address phase until the matching response handshake.
  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } arb_state_t;

  // Width of a master index; kept at least one bit so ports never collapse.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_arbiter_rr_select.sv
// Combinational round-robin pick: the first requester at or after ptr_i,
// wrapping modulo N.
module axil_arbiter_rr_select
  import axil_arbiter_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] winner_o,
  output logic           any_req_o
);

  logic [IDW-1:0] idx;

  // Scan N candidates starting at the pointer; the first hit wins.
  always_comb begin
    // NOTE: every output and temporary gets a default before any branch, so no
    // path through the block leaves a value held and no latch is inferred.
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr_i) + k) % N);
      if (!any_req_o && req_i[idx]) begin
        winner_o  = idx;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_arbiter.sv
// Shares one AXI-Lite master port between NUM_MASTERS requesters with
// round-robin arbitration and exactly one transaction in flight, end to end.
// Upstream ports are flattened: master i occupies slice i of each bus.
module axil_arbiter
  import axil_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  localparam int STRB_WIDTH  = DATA_WIDTH / 8,
  localparam int IDW         = id_width(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              reset,
  // upstream requesters
  input  logic [NUM_MASTERS-1:0]            s_awvalid_i,
  output logic [NUM_MASTERS-1:0]            s_awready_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic [NUM_MASTERS*3-1:0]          s_awprot_i,
  input  logic [NUM_MASTERS-1:0]            s_wvalid_i,
  output logic [NUM_MASTERS-1:0]            s_wready_o,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata_i,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] s_wstrb_i,
  output logic [NUM_MASTERS-1:0]            s_bvalid_o,
  input  logic [NUM_MASTERS-1:0]            s_bready_i,
  output logic [NUM_MASTERS*2-1:0]          s_bresp_o,
  input  logic [NUM_MASTERS-1:0]            s_arvalid_i,
  output logic [NUM_MASTERS-1:0]            s_arready_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr_i,
  input  logic [NUM_MASTERS*3-1:0]          s_arprot_i,
  output logic [NUM_MASTERS-1:0]            s_rvalid_o,
  input  logic [NUM_MASTERS-1:0]            s_rready_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_rdata_o,
  output logic [NUM_MASTERS*2-1:0]          s_rresp_o,
  // shared downstream port
  output logic                              m_awvalid_o,
  input  logic                              m_awready_i,
  output logic [ADDR_WIDTH-1:0]             m_awaddr_o,
  output logic [2:0]                        m_awprot_o,
  output logic                              m_wvalid_o,
  input  logic                              m_wready_i,
  output logic [DATA_WIDTH-1:0]             m_wdata_o,
  output logic [STRB_WIDTH-1:0]             m_wstrb_o,
  input  logic                              m_bvalid_i,
  output logic                              m_bready_o,
  input  logic [1:0]                        m_bresp_i,
  output logic                              m_arvalid_o,
  input  logic                              m_arready_i,
  output logic [ADDR_WIDTH-1:0]             m_araddr_o,
  output logic [2:0]                        m_arprot_o,
  input  logic                              m_rvalid_i,
  output logic                              m_rready_o,
  input  logic [DATA_WIDTH-1:0]             m_rdata_i,
  input  logic [1:0]                        m_rresp_i,
  // status
  output logic [IDW-1:0]                    grant_id_o,
  output logic                              busy_o
);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;

  logic [NUM_MASTERS-1:0] req;
  logic [IDW-1:0]         winner;
  logic                   any_req;
  logic [IDW-1:0]         next_ptr;

  // Channel windows: which handshake the granted master may currently see.
  logic aw_open, w_open, b_open, ar_open, r_open;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Per-master views of the flattened upstream buses.
  logic [ADDR_WIDTH-1:0] awaddr_arr [NUM_MASTERS];
  logic [2:0]            awprot_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr  [NUM_MASTERS];
  logic [STRB_WIDTH-1:0] wstrb_arr  [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] araddr_arr [NUM_MASTERS];
  logic [2:0]            arprot_arr [NUM_MASTERS];

  // A bare W beat is not a request; only an address phase competes.
  assign req = s_awvalid_i | s_arvalid_i;

  axil_arbiter_rr_select #(
    .N   (NUM_MASTERS),
    .IDW (IDW)
  ) u_rr_select (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // The pointer moves past the master that just finished, so nobody is
  // served twice in a row while someone else is waiting.
  assign next_ptr = (grant_q == IDW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;

  // Downstream handshakes.
  assign aw_hs = m_awvalid_o & m_awready_i;
  assign w_hs  = m_wvalid_o  & m_wready_i;
  assign b_hs  = m_bvalid_i  & m_bready_o;
  assign ar_hs = m_arvalid_o & m_arready_i;
  assign r_hs  = m_rvalid_i  & m_rready_o;

  // State, grant, pointer and write-progress registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic and channel windows.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_open   = 1'b0;
    w_open    = 1'b0;
    b_open    = 1'b0;
    ar_open   = 1'b0;
    r_open    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          // A master offering both address phases gets its write first.
          state_d = s_awvalid_i[winner] ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: begin
        ar_open = 1'b1;
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        r_open = 1'b1;
        if (r_hs) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      WR_ADDR: begin
        // AW and W run independently; each closes after its own handshake.
        aw_open = !aw_done_q;
        w_open  = !w_done_q;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q  | w_hs;
        end
      end
      WR_RESP: begin
        b_open = 1'b1;
        if (b_hs) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream side: payload muxed on the registered grant, valid/ready gated
  // by the open window.
  assign m_awvalid_o = aw_open & s_awvalid_i[grant_q];
  assign m_awaddr_o  = awaddr_arr[grant_q];
  assign m_awprot_o  = awprot_arr[grant_q];
  assign m_wvalid_o  = w_open & s_wvalid_i[grant_q];
  assign m_wdata_o   = wdata_arr[grant_q];
  assign m_wstrb_o   = wstrb_arr[grant_q];
  assign m_bready_o  = b_open & s_bready_i[grant_q];
  assign m_arvalid_o = ar_open & s_arvalid_i[grant_q];
  assign m_araddr_o  = araddr_arr[grant_q];
  assign m_arprot_o  = arprot_arr[grant_q];
  assign m_rready_o  = r_open & s_rready_i[grant_q];

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != IDLE);

  // Upstream side: unpack the buses and steer handshakes to the granted
  // master only; responses are broadcast but qualified by their valid.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
    logic granted;
    assign granted = (grant_q == IDW'(i));

    assign awaddr_arr[i] = s_awaddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign awprot_arr[i] = s_awprot_i[i*3 +: 3];
    assign wdata_arr[i]  = s_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_arr[i]  = s_wstrb_i[i*STRB_WIDTH +: STRB_WIDTH];
    assign araddr_arr[i] = s_araddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign arprot_arr[i] = s_arprot_i[i*3 +: 3];

    assign s_awready_o[i] = aw_open & granted & m_awready_i;
    assign s_wready_o[i]  = w_open  & granted & m_wready_i;
    assign s_arready_o[i] = ar_open & granted & m_arready_i;
    assign s_bvalid_o[i]  = b_open  & granted & m_bvalid_i;
    assign s_rvalid_o[i]  = r_open  & granted & m_rvalid_i;

    assign s_bresp_o[i*2 +: 2]                 = m_bresp_i;
    assign s_rresp_o[i*2 +: 2]                 = m_rresp_i;
    assign s_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = m_rdata_i;
  end

endmodule

// File: tb/tb_axil_arbiter.sv
// Directed bench for axil_arbiter with two upstream masters and a simple
// downstream register slave. Read data returned by the slave is addr ^ A5A50000;
// a read of 0xFFFC returns SLVERR.
module tb_axil_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int IW = 1;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT nets
  logic [NM-1:0]    s_awvalid_i, s_awready_o, s_wvalid_i, s_wready_o;
  logic [NM-1:0]    s_bvalid_o, s_bready_i, s_arvalid_i, s_arready_o;
  logic [NM-1:0]    s_rvalid_o, s_rready_i;
  logic [NM*AW-1:0] s_awaddr_i, s_araddr_i;
  logic [NM*3-1:0]  s_awprot_i, s_arprot_i;
  logic [NM*DW-1:0] s_wdata_i, s_rdata_o;
  logic [NM*SW-1:0] s_wstrb_i;
  logic [NM*2-1:0]  s_bresp_o, s_rresp_o;
  logic             m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
  logic             m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i;
  logic             m_rvalid_i, m_rready_o;
  logic [AW-1:0]    m_awaddr_o, m_araddr_o;
  logic [2:0]       m_awprot_o, m_arprot_o;
  logic [DW-1:0]    m_wdata_o, m_rdata_i;
  logic [SW-1:0]    m_wstrb_o;
  logic [1:0]       m_bresp_i, m_rresp_i;
  logic [IW-1:0]    grant_id_o;
  logic             busy_o;

  // Per-master driver variables
  logic          ar_v [NM], aw_v [NM], w_v [NM], r_rdy [NM], b_rdy [NM];
  logic [AW-1:0] ar_a [NM], aw_a [NM];
  logic [DW-1:0] w_d [NM];
  logic [SW-1:0] w_s [NM];

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      s_arvalid_i[i]        = ar_v[i];
      s_awvalid_i[i]        = aw_v[i];
      s_wvalid_i[i]         = w_v[i];
      s_rready_i[i]         = r_rdy[i];
      s_bready_i[i]         = b_rdy[i];
      s_araddr_i[i*AW +: AW] = ar_a[i];
      s_awaddr_i[i*AW +: AW] = aw_a[i];
      s_wdata_i[i*DW +: DW]  = w_d[i];
      s_wstrb_i[i*SW +: SW]  = w_s[i];
    end
  end

  // Master 0 uses prot 3'b010, master 1 uses 3'b001.
  assign s_awprot_i = {3'b001, 3'b010};
  assign s_arprot_i = {3'b001, 3'b010};

  axil_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_awvalid_i (s_awvalid_i),
    .s_awready_o (s_awready_o),
    .s_awaddr_i  (s_awaddr_i),
    .s_awprot_i  (s_awprot_i),
    .s_wvalid_i  (s_wvalid_i),
    .s_wready_o  (s_wready_o),
    .s_wdata_i   (s_wdata_i),
    .s_wstrb_i   (s_wstrb_i),
    .s_bvalid_o  (s_bvalid_o),
    .s_bready_i  (s_bready_i),
    .s_bresp_o   (s_bresp_o),
    .s_arvalid_i (s_arvalid_i),
    .s_arready_o (s_arready_o),
    .s_araddr_i  (s_araddr_i),
    .s_arprot_i  (s_arprot_i),
    .s_rvalid_o  (s_rvalid_o),
    .s_rready_i  (s_rready_i),
    .s_rdata_o   (s_rdata_o),
    .s_rresp_o   (s_rresp_o),
    .m_awvalid_o (m_awvalid_o),
    .m_awready_i (m_awready_i),
    .m_awaddr_o  (m_awaddr_o),
    .m_awprot_o  (m_awprot_o),
    .m_wvalid_o  (m_wvalid_o),
    .m_wready_i  (m_wready_i),
    .m_wdata_o   (m_wdata_o),
    .m_wstrb_o   (m_wstrb_o),
    .m_bvalid_i  (m_bvalid_i),
    .m_bready_o  (m_bready_o),
    .m_bresp_i   (m_bresp_i),
    .m_arvalid_o (m_arvalid_o),
    .m_arready_i (m_arready_i),
    .m_araddr_o  (m_araddr_o),
    .m_arprot_o  (m_arprot_o),
    .m_rvalid_i  (m_rvalid_i),
    .m_rready_o  (m_rready_o),
    .m_rdata_i   (m_rdata_i),
    .m_rresp_i   (m_rresp_i),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o)
  );

  // ---------------- downstream slave model ----------------
  int            cyc = 0;
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, b_hs_cyc = 0;
  int            b_delay = 0;
  int            b_ctr = 0;
  logic          aw_got = 1'b0, w_got = 1'b0, aw_stall = 1'b0;
  logic [AW-1:0] last_awaddr = '0;
  logic [2:0]    last_awprot = '0, last_arprot = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [SW-1:0] last_wstrb = '0;
  int            ar_log [$];

  assign m_awready_i = !aw_got && !aw_stall;
  assign m_wready_i  = !w_got;
  assign m_arready_i = !m_rvalid_i;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reset) begin
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      b_ctr      <= 0;
      m_bvalid_i <= 1'b0;
      m_bresp_i  <= 2'b00;
      m_rvalid_i <= 1'b0;
      m_rdata_i  <= '0;
      m_rresp_i  <= 2'b00;
    end else begin
      if (m_awvalid_o && m_awready_i) begin
        aw_got      <= 1'b1;
        aw_cnt      <= aw_cnt + 1;
        last_awaddr <= m_awaddr_o;
        last_awprot <= m_awprot_o;
      end
      if (m_wvalid_o && m_wready_i) begin
        w_got      <= 1'b1;
        w_cnt      <= w_cnt + 1;
        last_wdata <= m_wdata_o;
        last_wstrb <= m_wstrb_o;
      end
      if (aw_got && w_got && !m_bvalid_i) begin
        if (b_ctr >= b_delay) begin
          m_bvalid_i <= 1'b1;
          m_bresp_i  <= 2'b00;
          b_ctr      <= 0;
        end else begin
          b_ctr <= b_ctr + 1;
        end
      end
      if (m_bvalid_i && m_bready_o) begin
        m_bvalid_i <= 1'b0;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
        b_cnt      <= b_cnt + 1;
        b_hs_cyc   <= cyc;
      end
      if (m_arvalid_o && m_arready_i) begin
        m_rvalid_i  <= 1'b1;
        m_rdata_i   <= m_araddr_o ^ 32'hA5A5_0000;
        m_rresp_i   <= (m_araddr_o == 32'h0000_FFFC) ? 2'b10 : 2'b00;
        last_arprot <= m_arprot_o;
        ar_log.push_back(int'(grant_id_o));
      end
      if (m_rvalid_i && m_rready_o) m_rvalid_i <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic apply_reset();
    for (int i = 0; i < NM; i++) begin
      ar_v[i] = 1'b0; aw_v[i] = 1'b0; w_v[i] = 1'b0; r_rdy[i] = 1'b0; b_rdy[i] = 1'b0;
      ar_a[i] = '0; aw_a[i] = '0; w_d[i] = '0; w_s[i] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One read from master m; ready_cyc reports the cycle stamp where arready was seen.
  task automatic do_read(input int m, input logic [AW-1:0] addr,
                         output logic [DW-1:0] rdata, output logic [1:0] rresp,
                         output int ready_cyc);
    logic seen;
    ar_v[m] = 1'b1; ar_a[m] = addr; r_rdy[m] = 1'b1;
    rdata = '0; rresp = 2'b11; ready_cyc = -1; seen = 1'b0;
    for (int t = 0; t < TMO && !seen; t++) begin
      @(negedge clk);
      if (s_arready_o[m]) begin
        seen = 1'b1; ready_cyc = cyc;
        @(posedge clk); #1 ar_v[m] = 1'b0;
      end
    end
    check($sformatf("m%0d ar handshake", m), seen, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < TMO && !seen; t++) begin
      @(negedge clk);
      if (s_rvalid_o[m]) begin
        seen = 1'b1; rdata = s_rdata_o[m*DW +: DW]; rresp = s_rresp_o[m*2 +: 2];
        @(posedge clk); #1 r_rdy[m] = 1'b0;
      end
    end
    check($sformatf("m%0d r handshake", m), seen, 1'b1);
  endtask

  // One write from master m; W is presented lead cycles ahead of AW.
  task automatic do_write(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int lead, output logic [1:0] bresp);
    logic aw_ok, w_ok, seen, aw_now, w_now;
    aw_a[m] = addr; w_d[m] = data; w_s[m] = 4'hF; w_v[m] = 1'b1;
    if (lead > 0) begin
      repeat (lead) @(posedge clk);
      #1;
    end
    aw_v[m] = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; bresp = 2'b11;
    for (int t = 0; t < TMO && !(aw_ok && w_ok); t++) begin
      @(negedge clk);
      aw_now = aw_v[m] && s_awready_o[m];
      w_now  = w_v[m] && s_wready_o[m];
      if (aw_now || w_now) begin
        @(posedge clk);
        #1;
        if (aw_now) begin aw_v[m] = 1'b0; aw_ok = 1'b1; end
        if (w_now)  begin w_v[m]  = 1'b0; w_ok  = 1'b1; end
      end
    end
    check($sformatf("m%0d aw+w handshake", m), {aw_ok, w_ok}, 2'b11);
    b_rdy[m] = 1'b1; seen = 1'b0;
    for (int t = 0; t < TMO && !seen; t++) begin
      @(negedge clk);
      if (s_bvalid_o[m]) begin
        seen = 1'b1; bresp = s_bresp_o[m*2 +: 2];
        @(posedge clk); #1 b_rdy[m] = 1'b0;
      end
    end
    check($sformatf("m%0d b handshake", m), seen, 1'b1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [DW-1:0] rd0, rd1;
    logic [1:0]    rr0, rr1, br;
    int            rc0, rc1, aw0, w0, b0;

    apply_reset();
    @(negedge clk);
    check("reset busy", busy_o, 1'b0);
    check("reset grant", grant_id_o, '0);
    check("reset m valid/ready", {m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o}, 5'b0);
    check("reset s ready/valid", {s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o}, '0);

    // 1: single write from M0
    do_write(0, 32'h10, 32'hDEAD_BEEF, 0, br);
    @(negedge clk);
    check("t1 bresp", br, 2'b00);
    check("t1 aw count", aw_cnt, 1);
    check("t1 w count", w_cnt, 1);
    check("t1 b count", b_cnt, 1);
    check("t1 awaddr", last_awaddr, 32'h10);
    check("t1 wdata", last_wdata, 32'hDEAD_BEEF);
    check("t1 wstrb", last_wstrb, 4'hF);
    check("t1 awprot", last_awprot, 3'b010);
    check("t1 idle", busy_o, 1'b0);

    // 2: both masters read back to back; pointer restarted at 0
    apply_reset();
    ar_log.delete();
    fork
      for (int k = 0; k < 8; k++) begin
        do_read(0, 32'h0000_0000 + 32'(k*4), rd0, rr0, rc0);
        check($sformatf("t2 m0 rdata %0d", k), rd0, (32'(k*4)) ^ 32'hA5A5_0000);
        check($sformatf("t2 m0 rresp %0d", k), rr0, 2'b00);
      end
      for (int k = 0; k < 8; k++) begin
        do_read(1, 32'h0000_0100 + 32'(k*4), rd1, rr1, rc1);
        check($sformatf("t2 m1 rdata %0d", k), rd1, (32'h100 + 32'(k*4)) ^ 32'hA5A5_0000);
        check($sformatf("t2 m1 rresp %0d", k), rr1, 2'b00);
      end
    join
    check("t2 grant count", ar_log.size(), 16);
    for (int k = 0; k < ar_log.size() && k < 16; k++)
      check($sformatf("t2 grant order %0d", k), ar_log[k], k % 2);

    // 3a: W three cycles ahead of AW
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    do_write(1, 32'h20, 32'h1234_5678, 3, br);
    @(negedge clk);
    check("t3a bresp", br, 2'b00);
    check("t3a counts", {aw_cnt - aw0, w_cnt - w0, b_cnt - b0}, {32'd1, 32'd1, 32'd1});
    check("t3a wdata", last_wdata, 32'h1234_5678);
    // 3b: same-cycle upstream, downstream AW held off so W completes first
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    fork
      do_write(0, 32'h24, 32'hCAFE_F00D, 0, br);
      begin
        aw_stall = 1'b1;
        repeat (6) @(posedge clk);
        #1 aw_stall = 1'b0;
      end
    join
    @(negedge clk);
    check("t3b bresp", br, 2'b00);
    check("t3b counts", {aw_cnt - aw0, w_cnt - w0, b_cnt - b0}, {32'd1, 32'd1, 32'd1});
    check("t3b awaddr", last_awaddr, 32'h24);

    // 4: M1 waits on a slow M0 write; granted one cycle after the B handshake,
    // so arready is first seen two cycle stamps after it
    b_delay = 20;
    fork
      do_write(0, 32'h30, 32'h0BAD_F00D, 0, br);
      begin
        repeat (3) @(negedge clk);
        do_read(1, 32'h44, rd1, rr1, rc1);
      end
    join
    b_delay = 0;
    check("t4 bresp", br, 2'b00);
    check("t4 m1 grant timing", rc1, b_hs_cyc + 2);
    check("t4 m1 rdata", rd1, 32'h44 ^ 32'hA5A5_0000);

    // 5: slave error passes through; leaves the pointer at 1
    do_read(0, 32'h0000_FFFC, rd0, rr0, rc0);
    check("t5 rresp", rr0, 2'b10);
    check("t5 rdata", rd0, 32'hA5A5_FFFC);
    check("t5 arprot", last_arprot, 3'b010);

    // 6: reset while M1 sits in the data phase
    ar_v[1] = 1'b1; ar_a[1] = 32'h40; r_rdy[1] = 1'b0;
    rc1 = 0;
    for (int t = 0; t < TMO && rc1 == 0; t++) begin
      @(negedge clk);
      if (s_arready_o[1]) begin
        rc1 = 1;
        @(posedge clk); #1 ar_v[1] = 1'b0;
      end
    end
    check("t6 ar handshake", rc1, 1);
    repeat (2) @(negedge clk);
    check("t6 pre rvalid", s_rvalid_o[1], 1'b1);
    check("t6 pre grant", grant_id_o, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6 busy", busy_o, 1'b0);
    check("t6 grant", grant_id_o, 1'b0);
    check("t6 m valid/ready", {m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o}, 5'b0);
    check("t6 s ready/valid", {s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o}, '0);
    reset = 1'b0;
    ar_log.delete();
    fork
      do_read(0, 32'h50, rd0, rr0, rc0);
      do_read(1, 32'h54, rd1, rr1, rc1);
    join
    check("t6 first grant after reset", ar_log.size() > 0 ? ar_log[0] : -1, 0);
    check("t6 m0 rdata", rd0, 32'h50 ^ 32'hA5A5_0000);
    check("t6 m1 rdata", rd1, 32'h54 ^ 32'hA5A5_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
